// File: rtl/kalman_innov_pipe.sv
// kalman_innov_pipe: two-stage pipelined innovation adder S = P00 + R[ch].
// The adder works in unsigned fixed point and saturates at full scale.
// Each channel holds its own R value, which can be reprogrammed at run time.
// Valid/ready handshakes are used on both the input and the output side.
// Optional feature macro: KALMAN_INNOV_STATS_EN. It adds sat_clr and
// sat_count, a saturating count of output handshakes that carried s_sat = 1.
module kalman_innov_pipe #(
    parameter int DATA_W    = 23,
    parameter int FRAC_W    = 13,
    parameter int R_W       = 16,
    parameter int NUM_CH    = 1,
    parameter int R_DEFAULT = 250,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef KALMAN_INNOV_STATS_EN
    input  logic              sat_clr,
    output logic [15:0]       sat_count,
`endif
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [R_W-1:0]    cfg_r,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] p00_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] s_out,
    output logic              s_sat
);

    // FRAC_W only fixes where the binary point sits. P00, R and S all share
    // that binary point, so the adder never needs to know its value.
    localparam logic [R_W-1:0] R_RST = R_W'(R_DEFAULT);

    logic [R_W-1:0]    r_q [NUM_CH];
    logic [R_W-1:0]    r_sel_s;
    logic [DATA_W:0]   sum_s;
    logic              adv1_s;
    logic              adv2_s;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_val_q,   s1_val_d;
    logic              s1_sat_q,   s1_sat_d;
    logic [CH_W-1:0]   s1_ch_q,    s1_ch_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] s_out_q,     s_out_d;
    logic              s_sat_q,     s_sat_d;
    logic [CH_W-1:0]   out_ch_q,    out_ch_d;

    // Handshake: stage 2 drains when it is empty or when downstream takes the
    // result. Stage 1 takes a new sample when it is empty or when it can pass
    // its current sample on to stage 2.
    assign adv2_s   = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || adv2_s;
    assign adv1_s   = in_valid && in_ready;

    // R lookup. Channels outside the register file fall back to the reset value.
    always_comb begin
        r_sel_s = R_RST;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_ch == CH_W'(k)) begin
                r_sel_s = r_q[k];
            end else begin
                r_sel_s = r_sel_s;
            end
        end
    end

    assign sum_s = {1'b0, p00_in} + {{(DATA_W + 1 - R_W){1'b0}}, r_sel_s};

    // R register file. A write lands at the clock edge, so a sample accepted in
    // the same cycle still sees the old value. Out-of-range channels are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_q[k] <= R_RST;
            end
        end else if (cfg_we) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (cfg_ch == CH_W'(k)) begin
                    r_q[k] <= cfg_r;
                end else begin
                    r_q[k] <= r_q[k];
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_q[k] <= r_q[k];
            end
        end
    end

    // Stage 1 next state: load the saturated sum on accept, or empty the stage
    // when its contents move on to stage 2.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_val_d   = s1_val_q;
        s1_sat_d   = s1_sat_q;
        s1_ch_d    = s1_ch_q;
        if (adv1_s) begin
            s1_valid_d = 1'b1;
            s1_ch_d    = in_ch;
            if (sum_s[DATA_W]) begin
                s1_val_d = {DATA_W{1'b1}};
                s1_sat_d = 1'b1;
            end else begin
                s1_val_d = sum_s[DATA_W-1:0];
                s1_sat_d = 1'b0;
            end
        end else if (adv2_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 next state: take stage 1 when it advances. If nothing advances,
    // drop valid once downstream has taken the result. While backpressured,
    // the data fields are held unchanged.
    always_comb begin
        out_valid_d = out_valid_q;
        s_out_d     = s_out_q;
        s_sat_d     = s_sat_q;
        out_ch_d    = out_ch_q;
        if (adv2_s) begin
            out_valid_d = 1'b1;
            s_out_d     = s1_val_q;
            s_sat_d     = s1_sat_q;
            out_ch_d    = s1_ch_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers. Reset empties both stages and drops any in-flight data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_val_q    <= {DATA_W{1'b0}};
            s1_sat_q    <= 1'b0;
            s1_ch_q     <= {CH_W{1'b0}};
            out_valid_q <= 1'b0;
            s_out_q     <= {DATA_W{1'b0}};
            s_sat_q     <= 1'b0;
            out_ch_q    <= {CH_W{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_val_q    <= s1_val_d;
            s1_sat_q    <= s1_sat_d;
            s1_ch_q     <= s1_ch_d;
            out_valid_q <= out_valid_d;
            s_out_q     <= s_out_d;
            s_sat_q     <= s_sat_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign s_out     = s_out_q;
    assign s_sat     = s_sat_q;
    assign out_ch    = out_ch_q;

`ifdef KALMAN_INNOV_STATS_EN
    logic [15:0] sat_count_q;

    // Saturation statistics: count each saturated output handshake once and
    // stop at full scale. A clear wins over a coincident count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count_q <= 16'd0;
        end else if (sat_clr) begin
            sat_count_q <= 16'd0;
        end else if (out_valid_q && out_ready && s_sat_q && (sat_count_q != 16'hFFFF)) begin
            sat_count_q <= sat_count_q + 16'd1;
        end else begin
            sat_count_q <= sat_count_q;
        end
    end

    assign sat_count = sat_count_q;
`endif

endmodule
